dp_ram_port_ctrl: RTL and testbench



---
 rtl/dp_ram_pkg.sv | 19 +
 rtl/rsp_fifo.sv | 66 ++++++
 rtl/dp_ram_port_ctrl.sv | 73 +++++++
 tb/tb_dp_ram_port_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared defaults and command type for the dual-port RAM port controllers.
package dp_ram_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 256;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]  wdata;
  } cmd_t;

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO with push/pop and an occupancy count; storage clears on reset.
module rsp_fifo #(
  parameter  int WIDTH     = 32,
  parameter  int BUF_DEPTH = 3,
  localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  // Pointers wrap at BUF_DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    do_pop   = pop && (cnt_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

endmodule

// File: rtl/dp_ram_port_ctrl.sv
// Client-side controller for one synchronous port of the dual-port RAM.
module dp_ram_port_ctrl
  import dp_ram_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int BUF_DEPTH = 3,
  localparam int ADDR_W    = addr_w(DEPTH),
  localparam int OUT_W     = $clog2(BUF_DEPTH + 1) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic [OUT_W-1:0]  rd_outstanding
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic             accept;
  logic             pop;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] outstanding;

  // Reserving a slot for every read in flight means a push can never find the buffer full.
  assign outstanding = OUT_W'(cnt) + OUT_W'(pend_q);
  assign req_ready   = outstanding < OUT_W'(BUF_DEPTH);

  always_comb begin
    accept    = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready;
    pend_d    = accept && !req_we;
    ram_we    = accept && req_we;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  rsp_fifo #(
    .WIDTH    (WIDTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend_q),
    .push_data(ram_rdata),
    .pop      (pop),
    .rd_data  (rsp_rdata),
    .cnt      (cnt)
  );

  assign rsp_valid      = (cnt != '0);
  assign rd_outstanding = outstanding;

endmodule

// File: tb/tb_dp_ram_port_ctrl.sv
// Scoreboard bench for dp_ram_port_ctrl driving a read-first behavioural RAM.
module tb_dp_ram_port_ctrl;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 256;
  localparam int BUF_DEPTH = 3;
  localparam int ADDR_W    = 8;
  localparam int OUT_W     = $clog2(BUF_DEPTH + 1) + 1;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WIDTH-1:0]  req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [WIDTH-1:0]  ram_rdata;
  logic [OUT_W-1:0]  rd_outstanding;

  logic [WIDTH-1:0]  ramMem [DEPTH];
  logic [WIDTH-1:0]  refMem [DEPTH];
  logic [WIDTH-1:0]  expQ [$];

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int readCount = 0;
  int rspCount = 0;
  int lastPop = -1;
  int popGaps = 0;
  int stallCycles = 0;

  dp_ram_port_ctrl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata),
    .rd_outstanding(rd_outstanding)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read-first RAM port: a same-cycle write is not visible to the read.
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    ram_rdata <= ramMem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Responses are retired before new reads are queued so an empty queue really means unexpected.
  always @(posedge clk) begin
    cycleCount++;
    if (rst_n) begin
      checkOutput("outstanding_bound", 64'(rd_outstanding <= OUT_W'(BUF_DEPTH)), 64'd1);
      if (rsp_valid && rsp_ready) begin
        rspCount++;
        checkOutput("rsp_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) checkOutput("rsp_data", 64'(rsp_rdata), 64'(expQ.pop_front()));
        if (lastPop >= 0 && cycleCount != lastPop + 1) popGaps++;
        lastPop = cycleCount;
      end
      if (req_valid && req_ready) begin
        if (req_we) begin
          refMem[req_addr] = req_wdata;
        end else begin
          expQ.push_back(refMem[req_addr]);
          readCount++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] wdata);
    int waited = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    stallCycles += waited;
    checkOutput("issue_accepted", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int baseR;
    int baseS;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_outstanding", 64'(rd_outstanding), 64'd0);
    checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] preload");
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, ADDR_W'(a), WIDTH'(a * 3));
    applyStimulus(1'b1, 8'h20, 32'h11);

    $display("[TB] write then read, latency");
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF);
    baseS = rspCount;
    applyStimulus(1'b0, 8'h10, '0);
    checkOutput("lat_cycle_n1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("lat_cycle_n2_valid", 64'(rsp_valid), 64'd1);
    checkOutput("lat_cycle_n2_data", 64'(rsp_rdata), 64'hDEADBEEF);
    @(negedge clk);
    checkOutput("lat_cycle_n3_valid", 64'(rsp_valid), 64'd0);
    checkOutput("single_rsp_count", 64'(rspCount - baseS), 64'd1);

    $display("[TB] back-to-back reads");
    stallCycles = 0;
    lastPop = -1;
    popGaps = 0;
    baseS = rspCount;
    for (int a = 0; a < 8; a++) applyStimulus(1'b0, ADDR_W'(a), '0);
    repeat (4) @(negedge clk);
    checkOutput("b2b_no_stall", 64'(stallCycles), 64'd0);
    checkOutput("b2b_rsp_count", 64'(rspCount - baseS), 64'd8);
    checkOutput("b2b_consecutive", 64'(popGaps), 64'd0);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    baseR = readCount;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_addr = ADDR_W'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("bp_reads_accepted", 64'(readCount - baseR), 64'd3);
    checkOutput("bp_req_ready_low", 64'(req_ready), 64'd0);
    checkOutput("bp_outstanding", 64'(rd_outstanding), 64'd3);
    rsp_ready = 1'b1;
    baseS = rspCount;
    repeat (4) @(negedge clk);
    checkOutput("bp_drain_count", 64'(rspCount - baseS), 64'd3);
    checkOutput("bp_req_ready_back", 64'(req_ready), 64'd1);

    $display("[TB] read-before-write ordering");
    baseS = rspCount;
    applyStimulus(1'b0, 8'h20, '0);
    applyStimulus(1'b1, 8'h20, 32'h22);
    applyStimulus(1'b0, 8'h20, '0);
    repeat (4) @(negedge clk);
    checkOutput("rbw_rsp_count", 64'(rspCount - baseS), 64'd2);

    $display("[TB] asynchronous reset with reads in flight");
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = ADDR_W'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("rst_pre_outstanding", 64'(rd_outstanding), 64'd3);
    checkOutput("rst_pre_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_async_outstanding", 64'(rd_outstanding), 64'd0);
    checkOutput("rst_async_rdata", 64'(rsp_rdata), 64'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    baseS = rspCount;
    repeat (5) @(negedge clk);
    checkOutput("rst_no_stale_rsp", 64'(rspCount - baseS), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] random traffic");
    baseR = readCount;
    baseS = rspCount;
    repeat (10000) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = ($urandom_range(0, 3) == 0);
      req_addr  = ADDR_W'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("rand_rsp_vs_reads", 64'(rspCount - baseS), 64'(readCount - baseR));
    checkOutput("rand_queue_empty", 64'(expQ.size()), 64'd0);
    checkOutput("rand_outstanding_idle", 64'(rd_outstanding), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
